// File: rtl/axis_txc_pkg.sv
// Shared constants, enums and the control-word layout helper for the TXC generator.
package axis_txc_pkg;

  localparam logic [31:0] TXC_FLAG = 32'hA000_0000;

  localparam int W_FLAG      = 0;
  localparam int W_CSUM_CTRL = 1;
  localparam int W_CSUM_OFS  = 2;
  localparam int W_CSUM_INIT = 3;
  localparam int W_LEN       = 4;

  typedef enum logic [1:0] {
    CSUM_NONE    = 2'd0,
    CSUM_PARTIAL = 2'd1,
    CSUM_FULL    = 2'd2
  } csum_mode_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_END = 2'd2
  } txc_state_e;

  // Word contents for a given index; anything past the length word is zero padding.
  function automatic logic [31:0] ctrl_word(
    input int          idx,
    input csum_mode_e  mode,
    input logic [15:0] csum_begin,
    input logic [15:0] csum_insert,
    input logic [15:0] csum_init,
    input logic [31:0] len
  );
    logic [31:0] w;
    case (idx)
      W_FLAG:      w = TXC_FLAG;
      W_CSUM_CTRL: w = {30'b0, mode};
      W_CSUM_OFS:  w = {csum_insert, csum_begin};
      W_CSUM_INIT: w = {16'b0, csum_init};
      W_LEN:       w = len;
      default:     w = 32'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/axis_txc_len_fifo.sv
// Synchronous first-word-fall-through FIFO holding frame byte lengths.
// A push arriving while full is dropped and latches a sticky overflow flag.
module axis_txc_len_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign ovf   = ovf_q;
  assign dout  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + LW'(do_push) - LW'(do_pop);
    ovf_d    = ovf_q | (push & full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/axis_txc_gen.sv
// AXI-Stream TXC control-packet generator: one control packet per TXD frame.
// Define TXC_LEN_FIFO_EN to build the length FIFO; otherwise len is all-ones.
module axis_txc_gen
  import axis_txc_pkg::*;
#(
  parameter int NUM_CTRL_WORDS = 6,
  parameter int LEN_W          = 12,
  parameter int LEN_FIFO_DEPTH = 32,
  parameter int TDATA_WIDTH    = 32
) (
  input  logic                              axis_aclk,
  input  logic                              axis_aresetn,
  input  logic                              m_axis_txd_tvalid,
  input  logic                              m_axis_txd_tready,
  input  logic                              m_axis_txd_tlast,
  input  logic [LEN_W-1:0]                  tx_pkt_byte_cnt,
  input  logic                              tx_pkt_byte_cnt_vld,
  input  logic [1:0]                        csum_mode,
  input  logic [15:0]                       csum_begin,
  input  logic [15:0]                       csum_insert,
  input  logic [15:0]                       csum_init,
  output logic                              m_axis_txc_tvalid,
  output logic [31:0]                       m_axis_txc_tdata,
  output logic [3:0]                        m_axis_txc_tkeep,
  output logic                              m_axis_txc_tlast,
  input  logic                              m_axis_txc_tready,
  output logic                              len_fifo_ovf,
  output logic [$clog2(LEN_FIFO_DEPTH):0]   len_fifo_level
);

  localparam int IDX_W = $clog2(NUM_CTRL_WORDS);
  localparam int LVL_W = $clog2(LEN_FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CTRL_WORDS - 1);

  if (TDATA_WIDTH != 32) begin : g_bad_tdata_width
    $error("axis_txc_gen: TDATA_WIDTH must be 32");
  end
  if (NUM_CTRL_WORDS < 5 || NUM_CTRL_WORDS > 16) begin : g_bad_num_words
    $error("axis_txc_gen: NUM_CTRL_WORDS must be 5..16");
  end
  if (LEN_W < 12 || LEN_W > 16) begin : g_bad_len_w
    $error("axis_txc_gen: LEN_W must be 12..16");
  end
  if (LEN_FIFO_DEPTH < 4 || LEN_FIFO_DEPTH > 256 ||
      (LEN_FIFO_DEPTH & (LEN_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("axis_txc_gen: LEN_FIFO_DEPTH must be a power of two in 4..256");
  end

  txc_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              tvalid_q, tvalid_d;
  logic [31:0]       tdata_q, tdata_d;
  logic              tlast_q, tlast_d;
  csum_mode_e        mode_q, mode_d;
  logic [15:0]       begin_q, begin_d;
  logic [15:0]       insert_q, insert_d;
  logic [15:0]       init_q, init_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              frame_end_q, frame_end_d;

  logic              fifo_empty;
  logic [LEN_W-1:0]  fifo_dout;
  logic              fifo_pop;
  logic [LVL_W-1:0]  fifo_level;
  logic              fifo_ovf;
  logic              txd_last_beat;
  logic [IDX_W-1:0]  next_idx;

`ifdef TXC_LEN_FIFO_EN
  logic fifo_full;
  logic unused_fifo_full;

  axis_txc_len_fifo #(
    .WIDTH (LEN_W),
    .DEPTH (LEN_FIFO_DEPTH)
  ) u_len_fifo (
    .clk   (axis_aclk),
    .rst_n (axis_aresetn),
    .push  (tx_pkt_byte_cnt_vld),
    .din   (tx_pkt_byte_cnt),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level),
    .ovf   (fifo_ovf)
  );

  assign unused_fifo_full = fifo_full;
`else
  // Without the FIFO a length is always "available" and reads as all-ones.
  logic unused_fifo_inputs;

  assign fifo_empty         = 1'b0;
  assign fifo_dout          = {LEN_W{1'b1}};
  assign fifo_level         = '0;
  assign fifo_ovf           = 1'b0;
  assign unused_fifo_inputs = ^{tx_pkt_byte_cnt, tx_pkt_byte_cnt_vld, fifo_pop};
`endif

  assign txd_last_beat = m_axis_txd_tvalid & m_axis_txd_tready & m_axis_txd_tlast;
  assign next_idx      = idx_q + IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tlast_d     = tlast_q;
    mode_d      = mode_q;
    begin_d     = begin_q;
    insert_d    = insert_q;
    init_d      = init_q;
    len_d       = len_q;
    frame_end_d = frame_end_q;
    fifo_pop    = 1'b0;

    case (state_q)
      IDLE: begin
        frame_end_d = 1'b0;
        if (m_axis_txd_tvalid && !fifo_empty) begin
          state_d  = SEND;
          idx_d    = '0;
          tvalid_d = 1'b1;
          tdata_d  = TXC_FLAG;
          tlast_d  = 1'b0;
          mode_d   = csum_mode_e'(csum_mode);
          begin_d  = csum_begin;
          insert_d = csum_insert;
          init_d   = csum_init;
          len_d    = fifo_dout;
        end
      end

      SEND: begin
        if (txd_last_beat) begin
          frame_end_d = 1'b1;
        end
        // Output registers only move on an accepted beat, keeping data stable under stall.
        if (tvalid_q && m_axis_txc_tready) begin
          if (idx_q == LAST_IDX) begin
            fifo_pop = 1'b1;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = '0;
            idx_d    = '0;
            if (frame_end_q || txd_last_beat) begin
              state_d     = IDLE;
              frame_end_d = 1'b0;
            end else begin
              state_d = WAIT_END;
            end
          end else begin
            idx_d   = next_idx;
            tdata_d = ctrl_word(int'(next_idx), mode_q, begin_q, insert_q, init_q,
                                32'(len_q));
            tlast_d = (next_idx == LAST_IDX);
          end
        end
      end

      WAIT_END: begin
        if (txd_last_beat) begin
          state_d     = IDLE;
          frame_end_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      mode_q      <= CSUM_NONE;
      begin_q     <= '0;
      insert_q    <= '0;
      init_q      <= '0;
      len_q       <= '0;
      frame_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
      mode_q      <= mode_d;
      begin_q     <= begin_d;
      insert_q    <= insert_d;
      init_q      <= init_d;
      len_q       <= len_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign m_axis_txc_tvalid = tvalid_q;
  assign m_axis_txc_tdata  = tdata_q;
  assign m_axis_txc_tkeep  = 4'hF;
  assign m_axis_txc_tlast  = tlast_q;
  assign len_fifo_ovf      = fifo_ovf;
  assign len_fifo_level    = fifo_level;

endmodule

// File: tb/tb_axis_txc_gen.sv
// Directed/randomized bench for axis_txc_gen with a queue-based reference model.
module tb_axis_txc_gen;

  localparam int N     = 6;
  localparam int LEN_W = 12;
  localparam int DEPTH = 32;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              aresetn;
  logic              txd_tvalid, txd_tready, txd_tlast;
  logic [LEN_W-1:0]  byte_cnt;
  logic              byte_cnt_vld;
  logic [1:0]        csum_mode;
  logic [15:0]       csum_begin, csum_insert, csum_init;
  logic              txc_tvalid;
  logic [31:0]       txc_tdata;
  logic [3:0]        txc_tkeep;
  logic              txc_tlast;
  logic              txc_tready;
  logic              fifo_ovf;
  logic [LVL_W-1:0]  fifo_level;

  always #5 clk = ~clk;

  axis_txc_gen #(
    .NUM_CTRL_WORDS (N),
    .LEN_W          (LEN_W),
    .LEN_FIFO_DEPTH (DEPTH),
    .TDATA_WIDTH    (32)
  ) dut (
    .axis_aclk           (clk),
    .axis_aresetn        (aresetn),
    .m_axis_txd_tvalid   (txd_tvalid),
    .m_axis_txd_tready   (txd_tready),
    .m_axis_txd_tlast    (txd_tlast),
    .tx_pkt_byte_cnt     (byte_cnt),
    .tx_pkt_byte_cnt_vld (byte_cnt_vld),
    .csum_mode           (csum_mode),
    .csum_begin          (csum_begin),
    .csum_insert         (csum_insert),
    .csum_init           (csum_init),
    .m_axis_txc_tvalid   (txc_tvalid),
    .m_axis_txc_tdata    (txc_tdata),
    .m_axis_txc_tkeep    (txc_tkeep),
    .m_axis_txc_tlast    (txc_tlast),
    .m_axis_txc_tready   (txc_tready),
    .len_fifo_ovf        (fifo_ovf),
    .len_fifo_level      (fifo_level)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: pending lengths and sticky overflow.
  int          model_q[$];
  bit          model_ovf = 1'b0;
  logic [1:0]  e_mode;
  logic [15:0] e_beg, e_ins, e_init;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int exp_level();
`ifdef TXC_LEN_FIFO_EN
    return model_q.size();
`else
    return 0;
`endif
  endfunction

  function automatic bit exp_ovf();
`ifdef TXC_LEN_FIFO_EN
    return model_ovf;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_len();
`ifdef TXC_LEN_FIFO_EN
    if (model_q.size() > 0) return 32'(model_q[0]);
    return 32'hDEAD_BEEF;
`else
    return (32'd1 << LEN_W) - 32'd1;
`endif
  endfunction

  function automatic logic [31:0] exp_word(input int k, input logic [31:0] len);
    case (k)
      0:       return 32'hA000_0000;
      1:       return 32'(e_mode);
      2:       return 32'(e_ins) * 32'd65536 + 32'(e_beg);
      3:       return 32'(e_init);
      4:       return len;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_push(input int v);
`ifdef TXC_LEN_FIFO_EN
    if (model_q.size() >= DEPTH) model_ovf = 1'b1;
    else model_q.push_back(v);
`endif
  endtask

  task automatic model_pop();
`ifdef TXC_LEN_FIFO_EN
    if (model_q.size() > 0) void'(model_q.pop_front());
`endif
  endtask

  task automatic set_csum();
    e_mode      = 2'($urandom_range(0, 2));
    e_beg       = 16'($urandom);
    e_ins       = 16'($urandom);
    e_init      = 16'($urandom);
    csum_mode   = e_mode;
    csum_begin  = e_beg;
    csum_insert = e_ins;
    csum_init   = e_init;
  endtask

  task automatic push(input int v);
    byte_cnt     = LEN_W'(v);
    byte_cnt_vld = 1'b1;
    @(posedge clk); #1;
    byte_cnt_vld = 1'b0;
    model_push(v);
  endtask

  task automatic end_frame(input bit keep_valid);
    txd_tvalid = 1'b1;
    txd_tready = 1'b1;
    txd_tlast  = 1'b1;
    @(posedge clk); #1;
    txd_tready = 1'b0;
    txd_tlast  = 1'b0;
    txd_tvalid = keep_valid;
  endtask

  // Consume one control packet, checking every accepted beat and stall stability.
  task automatic collect(input bit stall, input int tl_at, input int abort_at,
                         input bit push_last, input int push_val, input string tag,
                         output int nb, output bit aborted);
    int          cyc;
    int          st;
    bit          held, pulsed, pushed, rdy;
    logic [31:0] prev, len;
    cyc = 0; st = 0; held = 0; pulsed = 0; pushed = 0; prev = '0;
    len = exp_len();
    nb = 0;
    aborted = 1'b0;
    while (nb < N && cyc < 60 && !aborted) begin
      if (txc_tvalid) begin
        if (nb == abort_at) begin
          aborted = 1'b1;
        end else begin
          if (held) chk($sformatf("%s stable%0d", tag, nb), txc_tdata, prev);
          rdy = stall ? ((st % 4) == 0 || (st % 4) == 3) : 1'b1;
          st++;
          txc_tready = rdy;
          if (nb == tl_at && !pulsed) begin
            txd_tready = 1'b1;
            txd_tlast  = 1'b1;
            pulsed     = 1'b1;
          end
          if (rdy) begin
            chk($sformatf("%s w%0d", tag, nb), txc_tdata, exp_word(nb, len));
            chk($sformatf("%s last%0d", tag, nb), 32'(txc_tlast), 32'(nb == N - 1));
            if (push_last && nb == N - 1) begin
              byte_cnt     = LEN_W'(push_val);
              byte_cnt_vld = 1'b1;
              pushed       = 1'b1;
            end
            nb++;
            held = 1'b0;
          end else begin
            held = 1'b1;
            prev = txc_tdata;
          end
        end
      end else begin
        if (held) chk($sformatf("%s hold_valid", tag), 32'(txc_tvalid), 32'd1);
        txc_tready = 1'b1;
      end
      if (!aborted) begin
        @(posedge clk); #1;
        txd_tready   = 1'b0;
        txd_tlast    = 1'b0;
        byte_cnt_vld = 1'b0;
        cyc++;
      end
    end
    txc_tready = 1'b0;
    if (!aborted) begin
      chk({tag, " beats"}, nb, N);
      if (pushed) model_push(push_val);
      if (nb == N) model_pop();
      chk({tag, " tvalid_after"}, 32'(txc_tvalid), 32'd0);
      chk({tag, " level"}, 32'(fifo_level), exp_level());
    end
  endtask

  initial begin
    int nb;
    bit ab;
    int seen;

    aresetn      = 1'b1;
    txd_tvalid   = 1'b0;
    txd_tready   = 1'b0;
    txd_tlast    = 1'b0;
    byte_cnt     = '0;
    byte_cnt_vld = 1'b0;
    csum_mode    = '0;
    csum_begin   = '0;
    csum_insert  = '0;
    csum_init    = '0;
    txc_tready   = 1'b0;
    e_mode = '0; e_beg = '0; e_ins = '0; e_init = '0;

    #2 aresetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst tvalid", 32'(txc_tvalid), 32'd0);
    chk("rst tdata", txc_tdata, 32'd0);
    chk("rst tlast", 32'(txc_tlast), 32'd0);
    chk("rst ovf", 32'(fifo_ovf), 32'd0);
    chk("rst level", 32'(fifo_level), 32'd0);
    chk("tkeep", 32'(txc_tkeep), 32'hF);
    aresetn = 1'b1;
    @(posedge clk); #1;

    // Basic packet at full throughput.
    set_csum();
    push('h05E);
    chk("push level", 32'(fifo_level), exp_level());
    txd_tvalid = 1'b1;
    collect(1'b0, -1, -1, 1'b0, 0, "pkt1", nb, ab);
    end_frame(1'b0);

    // Stalled packet, with a push landing on the same cycle as the pop.
    set_csum();
    push('h05E);
    txd_tvalid = 1'b1;
    collect(1'b1, -1, -1, 1'b1, 'h321, "pkt2", nb, ab);
    end_frame(1'b0);

    set_csum();
    txd_tvalid = 1'b1;
    collect(1'b0, -1, -1, 1'b0, 0, "pkt3", nb, ab);
    end_frame(1'b0);

    // Frame pending with no length available.
    set_csum();
`ifdef TXC_LEN_FIFO_EN
    txd_tvalid = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      seen += int'(txc_tvalid);
    end
    chk("empty wait beats", seen, 0);
`endif
    push('h100);
    txd_tvalid = 1'b1;
    collect(1'b0, -1, -1, 1'b0, 0, "pkt_wait", nb, ab);
    end_frame(1'b0);

    // Overflow the length FIFO, then drain it frame by frame.
    for (int i = 0; i < DEPTH + 1; i++) push(int'($urandom_range(0, (1 << LEN_W) - 1)));
    chk("ovf sticky", 32'(fifo_ovf), 32'(exp_ovf()));
    chk("full level", 32'(fifo_level), exp_level());

    txd_tvalid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      set_csum();
      collect((i % 3) == 0, ((i % 2) == 1) ? 2 : -1, -1, 1'b0, 0,
              $sformatf("drain%0d", i), nb, ab);
      if (i == DEPTH - 1) txd_tvalid = 1'b0;
      else if ((i % 2) == 0) end_frame(1'b1);
    end
    chk("ovf after drain", 32'(fifo_ovf), 32'(exp_ovf()));

    // Reset in the middle of a packet.
    set_csum();
    push(int'($urandom_range(1, (1 << LEN_W) - 1)));
    txd_tvalid = 1'b1;
    collect(1'b0, -1, 2, 1'b0, 0, "pkt_abort", nb, ab);
    chk("abort reached", 32'(ab), 32'd1);
    aresetn    = 1'b0;
    txd_tvalid = 1'b0;
    model_q.delete();
    model_ovf  = 1'b0;
    #1;
    chk("midrst tvalid", 32'(txc_tvalid), 32'd0);
    chk("midrst tlast", 32'(txc_tlast), 32'd0);
    chk("midrst level", 32'(fifo_level), 32'd0);
    chk("midrst ovf", 32'(fifo_ovf), 32'd0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(posedge clk); #1;
    set_csum();
    push(int'($urandom_range(1, (1 << LEN_W) - 1)));
    txd_tvalid = 1'b1;
    collect(1'b1, -1, -1, 1'b0, 0, "pkt_after_rst", nb, ab);
    end_frame(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
